// File: rtl/mem_ctrl_32to16.sv
// Bridges the 32-bit CPU load/store path onto a single-port 16-bit synchronous memory.
// Words are split into two halfword accesses and byte stores use read-modify-write.
module mem_ctrl_32to16 #(
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic                      cpu_req_write,
    input  logic [1:0]                cpu_req_size,
    input  logic                      cpu_req_signed,
    input  logic [MEM_ADDR_WIDTH:0]   cpu_req_addr,
    input  logic [31:0]               cpu_req_wdata,
    output logic                      cpu_resp_valid,
    output logic [31:0]               cpu_resp_rdata,
    output logic                      cpu_resp_error,
    input  logic [15:0]               MEM_MEMCTRL_from_mem_data,
    output logic                      MEMCTRL_MEM_to_mem_read_enable,
    output logic                      MEMCTRL_MEM_to_mem_write_enable,
    output logic                      MEMCTRL_MEM_to_mem_mem_enable,
    output logic [MEM_ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
    output logic [15:0]               MEMCTRL_MEM_to_mem_data
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WAIT,
        MERGE_WR,
        WR_LO,
        WR_HI,
        RESP
    } state_t;

    state_t                    state_reg;
    logic                      write_reg;
    logic [1:0]                size_reg;
    logic                      signed_reg;
    logic                      byte_sel_reg;
    logic [MEM_ADDR_WIDTH-1:0] lo_addr_reg;
    logic [31:0]               wdata_reg;
    logic [15:0]               lo_data_reg;
    logic [31:0]               rdata_reg;
    logic                      error_reg;

    logic                      req_legal;
    logic                      accept;
    logic [MEM_ADDR_WIDTH-1:0] hi_addr;
    logic [15:0]               merged_half;
    logic [31:0]               load_result;

    // Sign/zero extension of a completed load; words ignore the signed flag.
    function automatic logic [31:0] format_load(
        input logic [15:0] lo,
        input logic [15:0] hi,
        input logic [1:0]  sz,
        input logic        sgn,
        input logic        sel
    );
        logic [7:0]  b;
        logic [31:0] r;
        b = sel ? lo[15:8] : lo[7:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & lo[15]}}, lo};
            default: r = {hi, lo};
        endcase
        return r;
    endfunction

    always_comb begin
        req_legal = 1'b1;
        case (cpu_req_size)
            SZ_BYTE: req_legal = 1'b1;
            SZ_HALF: req_legal = ~cpu_req_addr[0];
            SZ_WORD: req_legal = (cpu_req_addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    assign accept      = cpu_req_valid && (state_reg == IDLE);
    assign hi_addr     = lo_addr_reg + MEM_ADDR_WIDTH'(1);
    assign merged_half = byte_sel_reg ? {wdata_reg[7:0], lo_data_reg[7:0]}
                                      : {lo_data_reg[15:8], wdata_reg[7:0]};

    // In WAIT the memory output is the last halfword read: the only one for
    // byte/half loads, the upper one for word loads.
    always_comb begin
        if (size_reg == SZ_WORD)
            load_result = format_load(lo_data_reg, MEM_MEMCTRL_from_mem_data,
                                      size_reg, signed_reg, byte_sel_reg);
        else
            load_result = format_load(MEM_MEMCTRL_from_mem_data, 16'h0000,
                                      size_reg, signed_reg, byte_sel_reg);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            size_reg     <= SZ_BYTE;
            signed_reg   <= 1'b0;
            byte_sel_reg <= 1'b0;
            lo_addr_reg  <= '0;
            wdata_reg    <= 32'h0;
            lo_data_reg  <= 16'h0;
            rdata_reg    <= 32'h0;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        write_reg    <= cpu_req_write;
                        size_reg     <= cpu_req_size;
                        signed_reg   <= cpu_req_signed;
                        byte_sel_reg <= cpu_req_addr[0];
                        lo_addr_reg  <= cpu_req_addr[MEM_ADDR_WIDTH:1];
                        wdata_reg    <= cpu_req_wdata;
                        if (!req_legal) begin
                            error_reg <= 1'b1;
                            rdata_reg <= 32'h0;
                            state_reg <= RESP;
                        end else if (cpu_req_write && cpu_req_size != SZ_BYTE) begin
                            state_reg <= WR_LO;
                        end else begin
                            state_reg <= RD_LO;
                        end
                    end
                end
                RD_LO: begin
                    if (!write_reg && size_reg == SZ_WORD)
                        state_reg <= RD_HI;
                    else
                        state_reg <= WAIT;
                end
                RD_HI: begin
                    lo_data_reg <= MEM_MEMCTRL_from_mem_data;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    if (write_reg) begin
                        lo_data_reg <= MEM_MEMCTRL_from_mem_data;
                        state_reg   <= MERGE_WR;
                    end else begin
                        rdata_reg <= load_result;
                        state_reg <= RESP;
                    end
                end
                MERGE_WR: state_reg <= RESP;
                WR_LO: begin
                    if (size_reg == SZ_WORD)
                        state_reg <= WR_HI;
                    else
                        state_reg <= RESP;
                end
                WR_HI: state_reg <= RESP;
                RESP: begin
                    rdata_reg <= 32'h0;
                    error_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Memory strobes depend on state alone, so an async reset drops them at once.
    always_comb begin
        MEMCTRL_MEM_to_mem_read_enable  = 1'b0;
        MEMCTRL_MEM_to_mem_write_enable = 1'b0;
        MEMCTRL_MEM_to_mem_address      = '0;
        MEMCTRL_MEM_to_mem_data         = 16'h0000;
        case (state_reg)
            RD_LO: begin
                MEMCTRL_MEM_to_mem_read_enable = 1'b1;
                MEMCTRL_MEM_to_mem_address     = lo_addr_reg;
            end
            RD_HI: begin
                MEMCTRL_MEM_to_mem_read_enable = 1'b1;
                MEMCTRL_MEM_to_mem_address     = hi_addr;
            end
            MERGE_WR: begin
                MEMCTRL_MEM_to_mem_write_enable = 1'b1;
                MEMCTRL_MEM_to_mem_address      = lo_addr_reg;
                MEMCTRL_MEM_to_mem_data         = merged_half;
            end
            WR_LO: begin
                MEMCTRL_MEM_to_mem_write_enable = 1'b1;
                MEMCTRL_MEM_to_mem_address      = lo_addr_reg;
                MEMCTRL_MEM_to_mem_data         = wdata_reg[15:0];
            end
            WR_HI: begin
                MEMCTRL_MEM_to_mem_write_enable = 1'b1;
                MEMCTRL_MEM_to_mem_address      = hi_addr;
                MEMCTRL_MEM_to_mem_data         = wdata_reg[31:16];
            end
            default: begin
                MEMCTRL_MEM_to_mem_read_enable  = 1'b0;
                MEMCTRL_MEM_to_mem_write_enable = 1'b0;
            end
        endcase
    end

    assign MEMCTRL_MEM_to_mem_mem_enable = MEMCTRL_MEM_to_mem_read_enable |
                                           MEMCTRL_MEM_to_mem_write_enable;
    assign cpu_req_ready  = (state_reg == IDLE);
    assign cpu_resp_valid = (state_reg == RESP);
    assign cpu_resp_rdata = rdata_reg;
    assign cpu_resp_error = error_reg;

endmodule

// File: tb/tb_mem_ctrl_32to16.sv
// Directed bench for mem_ctrl_32to16 with a behavioural 4096x16 synchronous memory.
module tb_mem_ctrl_32to16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_write = 1'b0;
    logic [1:0]  cpu_req_size = 2'b00;
    logic        cpu_req_signed = 1'b0;
    logic [12:0] cpu_req_addr = 13'h0;
    logic [31:0] cpu_req_wdata = 32'h0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_error;
    logic [15:0] mem_dout = 16'h0;
    logic        mem_re;
    logic        mem_we;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_din;

    logic [15:0] mem [0:4095];

    int n_cmp  = 0;
    int n_fail = 0;

    mem_ctrl_32to16 #(.MEM_ADDR_WIDTH(12)) dut (
        .clock                           (clock),
        .reset                           (reset),
        .cpu_req_valid                   (cpu_req_valid),
        .cpu_req_ready                   (cpu_req_ready),
        .cpu_req_write                   (cpu_req_write),
        .cpu_req_size                    (cpu_req_size),
        .cpu_req_signed                  (cpu_req_signed),
        .cpu_req_addr                    (cpu_req_addr),
        .cpu_req_wdata                   (cpu_req_wdata),
        .cpu_resp_valid                  (cpu_resp_valid),
        .cpu_resp_rdata                  (cpu_resp_rdata),
        .cpu_resp_error                  (cpu_resp_error),
        .MEM_MEMCTRL_from_mem_data       (mem_dout),
        .MEMCTRL_MEM_to_mem_read_enable  (mem_re),
        .MEMCTRL_MEM_to_mem_write_enable (mem_we),
        .MEMCTRL_MEM_to_mem_mem_enable   (mem_en),
        .MEMCTRL_MEM_to_mem_address      (mem_addr),
        .MEMCTRL_MEM_to_mem_data         (mem_din)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request from a negedge: accept on the next posedge, then watch 8 cycles.
    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [12:0] ad, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_en);
        int lat, pulses, en_cycles, en_bad;
        logic [31:0] rd;
        logic er;
        lat = 0; pulses = 0; en_cycles = 0; en_bad = 0; rd = 32'hx; er = 1'bx;
        chk({tag, ".ready"}, {31'h0, cpu_req_ready}, 32'h1);
        cpu_req_write = wr; cpu_req_size = sz; cpu_req_signed = sg;
        cpu_req_addr = ad; cpu_req_wdata = wd; cpu_req_valid = 1'b1;
        @(posedge clock);
        #1;
        cpu_req_valid = 1'b0;
        cpu_req_wdata = 32'h5555_AAAA;
        cpu_req_addr  = 13'h1555;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (mem_en) en_cycles++;
            if (mem_en !== (mem_re | mem_we)) en_bad++;
            if (cpu_resp_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = c; rd = cpu_resp_rdata; er = cpu_resp_error;
                end
            end
        end
        $display("req %s: wr=%0d size=%0d addr=0x%04h lat=%0d rdata=0x%08h err=%0d",
                 tag, wr, sz, ad, lat, rd, er);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".error"}, {31'h0, er}, {31'h0, exp_err});
        chk({tag, ".pulses"}, pulses, 1);
        chk({tag, ".en_cycles"}, en_cycles, exp_en);
        chk({tag, ".en_decode"}, en_bad, 0);
    endtask

    initial begin
        int pulses, en_cycles, first_c, second_c;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst.ready", {31'h0, cpu_req_ready}, 32'h1);
        chk("rst.resp_valid", {31'h0, cpu_resp_valid}, 32'h0);
        chk("rst.error", {31'h0, cpu_resp_error}, 32'h0);
        chk("rst.rdata", cpu_resp_rdata, 32'h0);
        chk("rst.strobes", {29'h0, mem_en, mem_re, mem_we}, 32'h0);
        chk("rst.addr_data", {4'h0, mem_addr, mem_din}, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // Word store/load
        run_req("sw_10", 1, 2'b10, 0, 13'h0010, 32'hDEADBEEF, 3, 32'h0, 0, 2);
        chk("mem8", {16'h0, mem[8]}, 32'h0000BEEF);
        chk("mem9", {16'h0, mem[9]}, 32'h0000DEAD);
        run_req("lw_10", 0, 2'b10, 1, 13'h0010, 32'h0, 4, 32'hDEADBEEF, 0, 2);

        // Byte read-modify-write and byte/half loads
        run_req("sh_02", 1, 2'b01, 0, 13'h0002, 32'hFFFF1234, 2, 32'h0, 0, 1);
        chk("mem1_a", {16'h0, mem[1]}, 32'h00001234);
        run_req("sb_03", 1, 2'b00, 0, 13'h0003, 32'h000000A5, 4, 32'h0, 0, 2);
        chk("mem1_b", {16'h0, mem[1]}, 32'h0000A534);
        run_req("lbs_03", 0, 2'b00, 1, 13'h0003, 32'h0, 3, 32'hFFFFFFA5, 0, 1);
        run_req("lbu_03", 0, 2'b00, 0, 13'h0003, 32'h0, 3, 32'h000000A5, 0, 1);
        run_req("lbu_02", 0, 2'b00, 0, 13'h0002, 32'h0, 3, 32'h00000034, 0, 1);
        run_req("lhs_02", 0, 2'b01, 1, 13'h0002, 32'h0, 3, 32'hFFFFA534, 0, 1);
        run_req("lhu_02", 0, 2'b01, 0, 13'h0002, 32'h0, 3, 32'h0000A534, 0, 1);
        run_req("sb_02", 1, 2'b00, 0, 13'h0002, 32'hFFFFFF5A, 4, 32'h0, 0, 2);
        chk("mem1_c", {16'h0, mem[1]}, 32'h0000A55A);
        run_req("lbs_02", 0, 2'b00, 1, 13'h0002, 32'h0, 3, 32'h0000005A, 0, 1);

        // Illegal requests
        run_req("lh_05", 0, 2'b01, 0, 13'h0005, 32'h0, 1, 32'h0, 1, 0);
        run_req("rsv_00", 0, 2'b11, 0, 13'h0000, 32'h0, 1, 32'h0, 1, 0);
        run_req("sw_12", 1, 2'b10, 0, 13'h0012, 32'h12345678, 1, 32'h0, 1, 0);
        chk("mem9_kept", {16'h0, mem[9]}, 32'h0000DEAD);

        // Top of memory
        run_req("sw_1ffc", 1, 2'b10, 0, 13'h1FFC, 32'hCAFEF00D, 3, 32'h0, 0, 2);
        chk("memffe", {16'h0, mem[12'hFFE]}, 32'h0000F00D);
        chk("memfff", {16'h0, mem[12'hFFF]}, 32'h0000CAFE);
        run_req("lw_1ffc", 0, 2'b10, 0, 13'h1FFC, 32'h0, 4, 32'hCAFEF00D, 0, 2);

        // Reset during RD_HI of a word load
        cpu_req_write = 0; cpu_req_size = 2'b10; cpu_req_signed = 0;
        cpu_req_addr = 13'h0010; cpu_req_valid = 1'b1;
        @(posedge clock); #1;
        cpu_req_valid = 1'b0;
        @(posedge clock); #1;
        chk("abort.in_rd_hi", {19'h0, mem_re, mem_addr}, {19'h0, 1'b1, 12'h009});
        reset = 1'b0;
        #1;
        chk("abort.strobes", {29'h0, mem_en, mem_re, mem_we}, 32'h0);
        chk("abort.resp_valid", {31'h0, cpu_resp_valid}, 32'h0);
        chk("abort.ready", {31'h0, cpu_req_ready}, 32'h1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pulses = 0; en_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (cpu_resp_valid) pulses++;
            if (mem_en) en_cycles++;
        end
        $display("abort: pulses=%0d en_cycles=%0d after release", pulses, en_cycles);
        chk("abort.no_resp", pulses, 0);
        chk("abort.no_access", en_cycles, 0);
        run_req("lhu_12", 0, 2'b01, 0, 13'h0012, 32'h0, 3, 32'h0000DEAD, 0, 1);

        // Back-to-back half stores with valid held high
        cpu_req_write = 1; cpu_req_size = 2'b01; cpu_req_signed = 0;
        cpu_req_addr = 13'h0100; cpu_req_wdata = 32'h00001111; cpu_req_valid = 1'b1;
        @(posedge clock); #1;
        cpu_req_addr = 13'h0102; cpu_req_wdata = 32'h00002222;
        pulses = 0; first_c = 0; second_c = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (cpu_resp_valid) begin
                pulses++;
                if (first_c == 0) first_c = c;
                else if (second_c == 0) second_c = c;
            end
            if (c == 4) cpu_req_valid = 1'b0;
        end
        $display("b2b: pulses=%0d first=%0d second=%0d", pulses, first_c, second_c);
        chk("b2b.pulses", pulses, 2);
        chk("b2b.first", first_c, 2);
        chk("b2b.second", second_c, 5);
        chk("mem80", {16'h0, mem[12'h080]}, 32'h00001111);
        chk("mem81", {16'h0, mem[12'h081]}, 32'h00002222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
